pmem_load_ctrl: RTL
===================

Name: pmem_load_ctrl

Overview:
- Sequences program-memory loading for the 12-bit microcontroller.
- Accepts instruction words from a host over a valid/ready stream and drives the Pmem load port (load enable, load address, load instruction).
- Holds the core's stage machine in LOAD until the last word is written, then issues a one-cycle release pulse so the core clears IR/DR/SR/PC/Acc and enters FETCH.
- Supports reload from the running state.

Parameters:
- ADDR_W, 8, width of Pmem address and length count
- INSTR_W, 12, instruction width

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_start  in  1  single-cycle request to begin a load
- i_len  in  ADDR_W  number of words to load, sampled with i_start
- i_abort  in  1  cancel a load in progress
- i_wr_valid  in  1  host word valid
- i_wr_data  in  INSTR_W  host instruction word
- o_wr_ready  out  1  controller accepts a word this cycle
- o_pmem_len  out  1  Pmem load enable
- o_pmem_laddr  out  ADDR_W  Pmem load address
- o_pmem_linstr  out  INSTR_W  Pmem load data
- o_core_hold  out  1  keeps the core stage machine in LOAD
- o_core_start  out  1  one-cycle release pulse to the core
- o_busy  out  1  high in LOAD (and CHECK)
- o_err  out  1  one-cycle error pulse

Behaviour:
- Reset (asynchronous, any state): state=IDLE, count=0.
  - Outputs: o_core_hold=1, o_wr_ready=0, o_pmem_len=0, o_pmem_laddr=0, o_pmem_linstr=0, o_core_start=0, o_busy=0, o_err=0.
- States: IDLE, LOAD, RELEASE, RUN.
- IDLE: o_core_hold=1.
  - i_start with i_len!=0: latch len, count=0, go to LOAD.
  - i_start with i_len==0: o_err pulses next cycle, stay in IDLE.
- LOAD: o_wr_ready=1, o_busy=1, o_core_hold=1.
  - A transfer occurs when i_wr_valid && o_wr_ready.
  - Registered write, latency 1: the cycle after a transfer, o_pmem_len=1, o_pmem_laddr=count, o_pmem_linstr=word. count increments.
  - o_pmem_len is 0 in every cycle that does not follow a transfer. o_pmem_laddr and o_pmem_linstr hold their last value.
  - Transfer with count==len-1: go to RELEASE (last write is issued in the RELEASE cycle).
  - i_abort has priority over a same-cycle transfer: that word is discarded, go to IDLE, o_err pulses next cycle, count=0.
  - i_start while in LOAD is ignored.
- RELEASE: exactly one cycle.
  - o_wr_ready=0, o_core_hold=1, o_core_start=1.
  - The last Pmem write lands on the same edge, so Pmem is complete before the core's first FETCH.
  - Next state is RUN.
- RUN: o_core_hold=0, o_wr_ready=0.
  - i_start with i_len!=0: o_core_hold=1 next cycle, count=0, go to LOAD (reload).
  - i_start with i_len==0: o_err pulses, stay in RUN.
  - i_abort is ignored.
- Address wrap: count is ADDR_W bits. Max len is 2^ADDR_W-1, so the address never wraps.
- i_wr_valid outside LOAD is ignored; no word is consumed.
- o_core_start and o_err are never high for more than one consecutive cycle.

Optional Feature:
- Macro: PMEM_LOAD_CKSUM_EN.
- Defined:
  - A running sum of accepted words, modulo 2^INSTR_W, is kept.
  - After the len-th word, state CHECK (o_wr_ready=1, o_busy=1, o_core_hold=1) accepts one extra word, which is not written to Pmem.
  - Word equals sum: go to RELEASE.
  - Word differs from sum: o_err pulses and go to IDLE, with the core held.
  - i_abort in CHECK behaves as it does in LOAD.
- Not defined: no CHECK state; LOAD goes directly to RELEASE.

Test Plan:
- Reset mid-load after 3 words → all outputs at reset values immediately (asynchronous); o_core_hold=1, state IDLE.
- i_start, i_len=10; words 0x001..0x00A sent back-to-back → o_pmem_len high for 10 consecutive cycles with laddr 0..9 and linstr 0x001..0x00A; o_core_start is a single pulse coincident with the laddr=9 write; o_core_hold falls the next cycle.
- i_len=4, i_wr_valid toggled every other cycle → exactly 4 Pmem writes with addr 0..3; no o_pmem_len in the gap cycles.
- i_len=0 in IDLE → o_err one-cycle pulse, no state change; i_abort together with valid on word 2 → word 2 not written, o_err pulse, IDLE.
- In RUN, i_start with i_len=2 → o_core_hold rises, words rewritten at addr 0 and 1, new o_core_start pulse.
- With PMEM_LOAD_CKSUM_EN, i_len=2, words 0x800 and 0x900, checksum 0x100 → release; checksum 0x101 → o_err pulse, IDLE, o_core_start stays 0.

Source files
------------

// File: rtl/pmem_load_ctrl_if.sv
// pmem_load_ctrl_if
// Bundles every non-clock/reset signal of the program-memory load
// controller.
//   master modport : host/core side (drives start, len, abort, wr_valid, wr_data)
//   slave  modport : pmem_load_ctrl (drives wr_ready, Pmem load port, core
//                    hold/start, busy, err)
// Parameters: ADDR_W (Pmem address and length width), INSTR_W (instruction width).
interface pmem_load_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
);
  logic               start;
  logic [ADDR_W-1:0]  len;
  logic               abort;
  logic               wr_valid;
  logic [INSTR_W-1:0] wr_data;
  logic               wr_ready;
  logic               pmem_len;
  logic [ADDR_W-1:0]  pmem_laddr;
  logic [INSTR_W-1:0] pmem_linstr;
  logic               core_hold;
  logic               core_start;
  logic               busy;
  logic               err;

  modport master (
    output start, len, abort, wr_valid, wr_data,
    input  wr_ready, pmem_len, pmem_laddr, pmem_linstr,
           core_hold, core_start, busy, err
  );

  modport slave (
    input  start, len, abort, wr_valid, wr_data,
    output wr_ready, pmem_len, pmem_laddr, pmem_linstr,
           core_hold, core_start, busy, err
  );
endinterface

// File: rtl/pmem_load_ctrl.sv
// pmem_load_ctrl
// Sequences program-memory loading for the 12-bit microcontroller. Words
// arrive from a host over a valid/ready stream and are written to Pmem one
// cycle after acceptance. The core is held in LOAD until the last word is
// written, then released with a one-cycle start pulse. Reload from RUN is
// supported.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : pmem_load_ctrl_if.slave
//          in : start, len, abort, wr_valid, wr_data
//          out: wr_ready, pmem_len, pmem_laddr, pmem_linstr,
//               core_hold, core_start, busy, err
// Optional feature macro: PMEM_LOAD_CKSUM_EN
//   When defined, a CHECK state follows the last word and accepts one extra
//   word that must equal the modulo-2^INSTR_W sum of the loaded words.
module pmem_load_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 12
) (
  input  logic            clk,
  input  logic            rst,
  pmem_load_ctrl_if.slave bus
);

`ifdef PMEM_LOAD_CKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RELEASE, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, RELEASE, RUN} state_t;
`endif

  state_t             state, state_next;
  logic [ADDR_W-1:0]  count;
  logic [ADDR_W-1:0]  len_q;
  logic               pmem_len_q;
  logic [ADDR_W-1:0]  pmem_laddr_q;
  logic [INSTR_W-1:0] pmem_linstr_q;
  logic               err_q;

  logic wr_ready, busy, core_hold, core_start;
  logic xfer, accept_start, count_clr, err_set;
  logic start_ok, start_bad, last_word;

`ifdef PMEM_LOAD_CKSUM_EN
  logic [INSTR_W-1:0] sum;
`endif

  assign start_ok  = bus.start && (bus.len != '0);
  assign start_bad = bus.start && (bus.len == '0);
  assign last_word = (count == len_q - ADDR_W'(1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-state outputs. abort is tested before wr_valid so a
  // word offered together with abort is never consumed.
  always_comb begin
    state_next   = state;
    wr_ready     = 1'b0;
    busy         = 1'b0;
    core_hold    = 1'b1;
    core_start   = 1'b0;
    xfer         = 1'b0;
    accept_start = 1'b0;
    count_clr    = 1'b0;
    err_set      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          accept_start = 1'b1;
          count_clr    = 1'b1;
          state_next   = LOAD;
        end else if (start_bad) begin
          err_set = 1'b1;
        end
      end
      LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (bus.abort) begin
          err_set    = 1'b1;
          count_clr  = 1'b1;
          state_next = IDLE;
        end else if (bus.wr_valid) begin
          xfer = 1'b1;
`ifdef PMEM_LOAD_CKSUM_EN
          if (last_word) state_next = CHECK;
`else
          if (last_word) state_next = RELEASE;
`endif
        end
      end
`ifdef PMEM_LOAD_CKSUM_EN
      CHECK: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (bus.abort) begin
          err_set    = 1'b1;
          count_clr  = 1'b1;
          state_next = IDLE;
        end else if (bus.wr_valid) begin
          if (bus.wr_data == sum) begin
            state_next = RELEASE;
          end else begin
            err_set    = 1'b1;
            count_clr  = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      RELEASE: begin
        core_start = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        core_hold = 1'b0;
        if (start_ok) begin
          accept_start = 1'b1;
          count_clr    = 1'b1;
          state_next   = LOAD;
        end else if (start_bad) begin
          err_set = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: Pmem write port is registered one cycle behind the accepted
  // word; address/data hold their last value when no write is issued.
  // err is suppressed for a cycle after it fires so it is always a single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      len_q         <= '0;
      pmem_len_q    <= 1'b0;
      pmem_laddr_q  <= '0;
      pmem_linstr_q <= '0;
      err_q         <= 1'b0;
    end else begin
      pmem_len_q <= xfer;
      err_q      <= err_set && !err_q;
      if (accept_start) len_q <= bus.len;
      if (xfer) begin
        pmem_laddr_q  <= count;
        pmem_linstr_q <= bus.wr_data;
        count         <= count + ADDR_W'(1);
      end
      if (count_clr) count <= '0;
    end
  end

`ifdef PMEM_LOAD_CKSUM_EN
  // Running checksum of accepted words, restarted with each new load
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               sum <= '0;
    else if (accept_start) sum <= '0;
    else if (xfer)         sum <= sum + bus.wr_data;
  end
`endif

  assign bus.wr_ready    = wr_ready;
  assign bus.busy        = busy;
  assign bus.core_hold   = core_hold;
  assign bus.core_start  = core_start;
  assign bus.pmem_len    = pmem_len_q;
  assign bus.pmem_laddr  = pmem_laddr_q;
  assign bus.pmem_linstr = pmem_linstr_q;
  assign bus.err         = err_q;

endmodule
